// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's two memory requesters, the arbiter and the memory model.
// The slave view belongs to the arbiter; the master view to the requesters plus memory.
interface mem_arbiter_if;
  logic        req0;
  logic [31:0] addr0;
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        gnt_id;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  modport slave (
    input  req0, addr0, req1, we1, addr1, wdata1, mem_rdata, mem_rdy,
    output ack0, ack1, rdata, err, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, addr0, req1, we1, addr1, wdata1, mem_rdata, mem_rdy,
    input  ack0, ack1, rdata, err, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port memory: fetch (port 0) vs stack/data (port 1),
// with a fetch starvation guard and an abort for memory that never answers.
module mem_arbiter #(
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] consec_reg, consec_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic [1:0]    ack_reg, ack_next;
  logic          err_reg, err_next;
  logic          busy_reg, busy_next;
  logic          gnt_reg, gnt_next;
  logic          mem_en_reg, mem_en_next;
  logic          mem_we_reg, mem_we_next;
  logic [31:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic [31:0]   rdata_reg, rdata_next;

  logic any_req;
  logic winner;
  logic timeout_hit;

  assign any_req     = bus.req0 | bus.req1;
  // Port 1 wins contention until fetch has been passed over MAX_CONSEC times in a row.
  assign winner      = bus.req1 & ~(bus.req0 & (consec_reg == CW'(MAX_CONSEC)));
  assign timeout_hit = (tcnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      consec_reg    <= '0;
      tcnt_reg      <= '0;
      ack_reg       <= '0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      gnt_reg       <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      consec_reg    <= consec_next;
      tcnt_reg      <= tcnt_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      gnt_reg       <= gnt_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_reg     <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (bus.mem_rdy || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_next       = '0;
    err_next       = 1'b0;
    busy_next      = busy_reg;
    gnt_next       = gnt_reg;
    mem_en_next    = mem_en_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rdata_next     = rdata_reg;
    tcnt_next      = tcnt_reg;
    consec_next    = consec_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          gnt_next       = winner;
          mem_en_next    = 1'b1;
          busy_next      = 1'b1;
          tcnt_next      = '0;
          mem_addr_next  = winner ? bus.addr1 : bus.addr0;
          mem_wdata_next = winner ? bus.wdata1 : '0;
          mem_we_next    = winner & bus.we1;
          if (!winner)
            consec_next = '0;
          else if (bus.req0 && consec_reg != CW'(MAX_CONSEC))
            consec_next = consec_reg + CW'(1);
        end
      end
      ACCESS: begin
        tcnt_next = tcnt_reg + TW'(1);
        if (bus.mem_rdy) begin
          rdata_next        = mem_we_reg ? '0 : bus.mem_rdata;
          mem_en_next       = 1'b0;
          ack_next[gnt_reg] = 1'b1;
        end else if (timeout_hit) begin
          rdata_next        = '0;
          err_next          = 1'b1;
          mem_en_next       = 1'b0;
          ack_next[gnt_reg] = 1'b1;
        end
      end
      RESP: begin
        busy_next = 1'b0;
        tcnt_next = '0;
      end
      default: ;
    endcase
  end

  assign bus.ack0      = ack_reg[0];
  assign bus.ack1      = ack_reg[1];
  assign bus.err       = err_reg;
  assign bus.busy      = busy_reg;
  assign bus.gnt_id    = gnt_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.rdata     = rdata_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized two-port traffic
// against a behavioural memory and a grant/data reference model.
module tb_mem_arbiter;
  localparam int MAX_CONSEC = 4;
  localparam int TIMEOUT    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_CONSEC(MAX_CONSEC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int mem_lat_lo = 1;
  int mem_lat_hi = 1;
  logic [31:0] store   [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  // Memory model: answers after a per-access latency, junk data until ready.
  int en_cnt = 0;
  int cur_lat = 1;
  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (en_cnt == 0) cur_lat = $urandom_range(mem_lat_hi, mem_lat_lo);
      en_cnt = en_cnt + 1;
      bus.mem_rdy = (en_cnt >= cur_lat);
      if (en_cnt >= cur_lat)
        bus.mem_rdata = store.exists(bus.mem_addr) ? store[bus.mem_addr] : default_word(bus.mem_addr);
      else
        bus.mem_rdata = $urandom;
    end else begin
      en_cnt = 0;
      bus.mem_rdy = 1'b0;
      bus.mem_rdata = $urandom;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.mem_en && bus.mem_rdy === 1'b1 && bus.mem_we)
      store[bus.mem_addr] = bus.mem_wdata;
  end

  // Protocol monitor: acks exclusive, err only alongside an ack.
  always @(negedge clk) begin
    if (!rst && (bus.ack0 || bus.ack1 || bus.err)) begin
      vectors++;
      if (bus.ack0 && bus.ack1) begin
        miscompares++; $display("FAIL ack_exclusive: ack0=%0b ack1=%0b, need at most one", bus.ack0, bus.ack1);
      end
      if (bus.err && !(bus.ack0 || bus.ack1)) begin
        miscompares++; $display("FAIL err_with_ack: err=1 with no ack");
      end
    end
  end

  task automatic drive_one(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int en_cyc, output int pre, output bit a0, output bit a1,
                           output logic [31:0] rd, output bit er, output logic [31:0] s_addr,
                           output logic [31:0] s_wdata, output bit s_we, output bit s_gnt,
                           output bit done, output bit ack_after);
    en_cyc = 0; pre = 0; a0 = 0; a1 = 0; rd = '0; er = 0; done = 0;
    s_addr = '0; s_wdata = '0; s_we = 0; s_gnt = 0; ack_after = 0;
    @(negedge clk);
    if (port) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; end
    else begin bus.req0 = 1'b1; bus.addr0 = addr; end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        if (en_cyc == 0) begin
          s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_we = bus.mem_we; s_gnt = bus.gnt_id;
        end
        en_cyc++;
      end else if (en_cyc == 0) pre++;
      if (bus.ack0 || bus.ack1) begin
        a0 = bus.ack0; a1 = bus.ack1; rd = bus.rdata; er = bus.err; done = 1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        $display("txn port=%0d we=%0d addr=%h rdata=%h err=%0d", port, we, addr, rd, er);
      end
    end
    @(negedge clk);
    ack_after = bus.ack0 | bus.ack1;
  endtask

  task automatic test_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we1 = 1'b0;
    bus.addr0 = 32'h100; bus.addr1 = 32'h200; bus.wdata1 = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.ack0, bus.ack1, bus.err, bus.busy, bus.mem_en, bus.mem_we, bus.gnt_id} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b (ack0,ack1,err,busy,mem_en,mem_we,gnt) need 0000000",
               {bus.ack0, bus.ack1, bus.err, bus.busy, bus.mem_en, bus.mem_we, bus.gnt_id});
    end
    vectors++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 96'b0) begin
      miscompares++;
      $display("FAIL reset_data: mem_addr=%h mem_wdata=%h rdata=%h need all 0", bus.mem_addr, bus.mem_wdata, bus.rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mem_en !== 1'b1 || bus.gnt_id !== 1'b1 || bus.mem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL first_grant: mem_en=%b gnt_id=%b mem_addr=%h need 1 1 00000200", bus.mem_en, bus.gnt_id, bus.mem_addr);
    end
    for (int i = 0; i < 50 && !(bus.ack0 || bus.ack1); i++) @(negedge clk);
    vectors++;
    if (bus.ack1 !== 1'b1 || bus.rdata !== default_word(32'h200)) begin
      miscompares++;
      $display("FAIL first_ack: ack1=%b rdata=%h need 1 %h", bus.ack1, bus.rdata, default_word(32'h200));
    end
    $display("txn port=1 we=0 addr=%h rdata=%h err=%0d", 32'h200, bus.rdata, bus.err);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int en_cyc, pre; bit a0, a1, er, s_we, s_gnt, done, aa; logic [31:0] rd, s_addr, s_wdata;
    store[32'h10] = 32'hDEAD_BEEF; ref_mem[32'h10] = 32'hDEAD_BEEF;
    mem_lat_lo = 2; mem_lat_hi = 2;
    drive_one(1'b0, 1'b0, 32'h10, 32'h0, en_cyc, pre, a0, a1, rd, er, s_addr, s_wdata, s_we, s_gnt, done, aa);
    vectors++;
    if (en_cyc !== 2 || pre !== 0) begin
      miscompares++; $display("FAIL fetch_en: mem_en cycles=%0d latency=%0d need 2 0", en_cyc, pre);
    end
    vectors++;
    if (s_addr !== 32'h10 || s_we !== 1'b0 || s_gnt !== 1'b0) begin
      miscompares++; $display("FAIL fetch_bus: addr=%h we=%b gnt=%b need 00000010 0 0", s_addr, s_we, s_gnt);
    end
    vectors++;
    if (!done || a0 !== 1'b1 || a1 !== 1'b0 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || aa !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_ack: ack0=%b ack1=%b rdata=%h err=%b ack_next=%b need 1 0 deadbeef 0 0", a0, a1, rd, er, aa);
    end
  endtask

  task automatic test_stack_write();
    int en_cyc, pre; bit a0, a1, er, s_we, s_gnt, done, aa; logic [31:0] rd, s_addr, s_wdata;
    mem_lat_lo = 1; mem_lat_hi = 1;
    drive_one(1'b1, 1'b1, 32'hFFFC, 32'h42, en_cyc, pre, a0, a1, rd, er, s_addr, s_wdata, s_we, s_gnt, done, aa);
    ref_mem[32'hFFFC] = 32'h42;
    vectors++;
    if (s_we !== 1'b1 || s_wdata !== 32'h42 || s_addr !== 32'hFFFC || s_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL write_bus: we=%b wdata=%h addr=%h gnt=%b need 1 00000042 0000fffc 1", s_we, s_wdata, s_addr, s_gnt);
    end
    vectors++;
    if (!done || a1 !== 1'b1 || a0 !== 1'b0 || rd !== 32'h0 || er !== 1'b0) begin
      miscompares++; $display("FAIL write_ack: ack1=%b ack0=%b rdata=%h err=%b need 1 0 0 0", a1, a0, rd, er);
    end
    drive_one(1'b1, 1'b0, 32'hFFFC, 32'h0, en_cyc, pre, a0, a1, rd, er, s_addr, s_wdata, s_we, s_gnt, done, aa);
    vectors++;
    if (a1 !== 1'b1 || rd !== 32'h42 || s_we !== 1'b0) begin
      miscompares++; $display("FAIL readback: ack1=%b rdata=%h we=%b need 1 00000042 0", a1, rd, s_we);
    end
  endtask

  task automatic test_timeout();
    int en_cyc, pre; bit a0, a1, er, s_we, s_gnt, done, aa; logic [31:0] rd, s_addr, s_wdata;
    mem_lat_lo = 1000; mem_lat_hi = 1000;
    drive_one(1'b1, 1'b0, 32'h40, 32'h0, en_cyc, pre, a0, a1, rd, er, s_addr, s_wdata, s_we, s_gnt, done, aa);
    vectors++;
    if (en_cyc !== TIMEOUT) begin
      miscompares++; $display("FAIL timeout_len: mem_en cycles=%0d need %0d", en_cyc, TIMEOUT);
    end
    vectors++;
    if (!done || a1 !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
      miscompares++; $display("FAIL timeout_ack: done=%b ack1=%b err=%b rdata=%h need 1 1 1 0", done, a1, er, rd);
    end
    mem_lat_lo = 1; mem_lat_hi = 1;
    drive_one(1'b0, 1'b0, 32'h44, 32'h0, en_cyc, pre, a0, a1, rd, er, s_addr, s_wdata, s_we, s_gnt, done, aa);
    vectors++;
    if (a0 !== 1'b1 || er !== 1'b0 || rd !== ref_read(32'h44) || en_cyc !== 1) begin
      miscompares++;
      $display("FAIL after_timeout: ack0=%b err=%b rdata=%h en=%0d need 1 0 %h 1", a0, er, rd, en_cyc, ref_read(32'h44));
    end
  endtask

  // Both requesters keep asking; counter assumed clear on entry.
  task automatic test_contention(input int n);
    logic [31:0] ra [2]; logic [31:0] rw [2]; bit rwe [2]; bit reraise [2];
    int acks = 0; int exp_port; int got_port; logic [31:0] exp_rd;
    mem_lat_lo = 1; mem_lat_hi = 1;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      ra[p] = {26'd0, 4'($urandom_range(15)), 2'b00}; rw[p] = $urandom; rwe[p] = (p == 1) && $urandom_range(1) == 1;
      reraise[p] = 0;
    end
    bus.req0 = 1'b1; bus.addr0 = ra[0];
    bus.req1 = 1'b1; bus.addr1 = ra[1]; bus.we1 = rwe[1]; bus.wdata1 = rw[1];
    for (int cyc = 0; cyc < 400 && acks < n; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (reraise[p]) begin
        reraise[p] = 0;
        ra[p] = {26'd0, 4'($urandom_range(15)), 2'b00}; rw[p] = $urandom; rwe[p] = (p == 1) && $urandom_range(1) == 1;
        if (p == 0) begin bus.req0 = 1'b1; bus.addr0 = ra[0]; end
        else begin bus.req1 = 1'b1; bus.addr1 = ra[1]; bus.we1 = rwe[1]; bus.wdata1 = rw[1]; end
      end
      if (bus.ack0 || bus.ack1) begin
        exp_port = (acks % (MAX_CONSEC + 1) == MAX_CONSEC) ? 0 : 1;
        got_port = bus.ack1 ? 1 : 0;
        exp_rd = rwe[got_port] ? 32'h0 : ref_read(ra[got_port]);
        vectors++;
        if (got_port != exp_port || bus.rdata !== exp_rd || bus.err !== 1'b0) begin
          miscompares++;
          $display("FAIL contention[%0d]: port=%0d rdata=%h err=%b need port=%0d rdata=%h err=0",
                   acks, got_port, bus.rdata, bus.err, exp_port, exp_rd);
        end
        $display("txn port=%0d we=%0d addr=%h rdata=%h err=%0d", got_port, rwe[got_port], ra[got_port], bus.rdata, bus.err);
        if (rwe[got_port]) ref_mem[ra[got_port]] = rw[got_port];
        if (got_port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        reraise[got_port] = 1;
        acks++;
        if (acks == n) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    vectors++;
    if (acks != n) begin
      miscompares++; $display("FAIL contention_count: acks=%0d need %0d", acks, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int stray = 0; bit seen = 0;
    mem_lat_lo = 5; mem_lat_hi = 5;
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 32'h80;
    bus.req1 = 1'b1; bus.addr1 = 32'h84; bus.we1 = 1'b1; bus.wdata1 = 32'hCAFE_0001;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_en;
    end
    vectors++;
    if (!seen || bus.gnt_id !== 1'b1) begin
      miscompares++; $display("FAIL midrst_grant: mem_en=%b gnt_id=%b need 1 1", seen, bus.gnt_id);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.mem_en, bus.busy, bus.ack0, bus.ack1, bus.gnt_id} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_state: mem_en,busy,ack0,ack1,gnt=%b need 00000", {bus.mem_en, bus.busy, bus.ack0, bus.ack1, bus.gnt_id});
    end
    rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.mem_en) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++; $display("FAIL midrst_quiet: %0d cycles with ack/mem_en after reset, need 0", stray);
    end
  endtask

  task automatic test_random(input int n);
    bit pend [2]; logic [31:0] ra [2]; logic [31:0] rw [2]; bit rwe [2];
    bit granted = 0; int exp_port = 0; int streak = 0; int acks = 0;
    logic [31:0] exp_rd; bit exp_we;
    mem_lat_lo = 1; mem_lat_hi = 4;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; ra[p] = '0; rw[p] = '0; rwe[p] = 0; end
    for (int cyc = 0; cyc < 5000 && acks < n; cyc++) begin
      @(negedge clk);
      if (bus.mem_en && !granted) begin
        granted = 1;
        if (pend[0] && pend[1]) exp_port = (streak == MAX_CONSEC) ? 0 : 1;
        else exp_port = pend[1] ? 1 : 0;
        if (exp_port == 0) streak = 0;
        else if (pend[0] && streak < MAX_CONSEC) streak++;
        exp_we = (exp_port == 1) && rwe[1];
        vectors++;
        if (bus.gnt_id !== exp_port[0] || bus.mem_addr !== ra[exp_port] || bus.mem_we !== exp_we ||
            (exp_we && bus.mem_wdata !== rw[1])) begin
          miscompares++;
          $display("FAIL rand_grant: gnt=%b addr=%h we=%b wdata=%h need gnt=%0d addr=%h we=%b wdata=%h",
                   bus.gnt_id, bus.mem_addr, bus.mem_we, bus.mem_wdata, exp_port, ra[exp_port], exp_we, rw[1]);
        end
      end
      if (bus.ack0 || bus.ack1) begin
        exp_we = (exp_port == 1) && rwe[1];
        exp_rd = exp_we ? 32'h0 : ref_read(ra[exp_port]);
        vectors++;
        if ({bus.ack1, bus.ack0} !== ((exp_port == 1) ? 2'b10 : 2'b01) || bus.rdata !== exp_rd || bus.err !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_ack: ack1,ack0=%b%b rdata=%h err=%b need port=%0d rdata=%h err=0",
                   bus.ack1, bus.ack0, bus.rdata, bus.err, exp_port, exp_rd);
        end
        $display("txn port=%0d we=%0d addr=%h rdata=%h err=%0d", exp_port, exp_we, ra[exp_port], bus.rdata, bus.err);
        if (exp_we) ref_mem[ra[1]] = rw[1];
        pend[exp_port] = 0;
        if (exp_port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        granted = 0;
        acks++;
      end else begin
        for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(2) == 0) begin
          pend[p] = 1;
          ra[p] = {27'd0, 3'($urandom_range(7)), 2'b00};
          rw[p] = $urandom;
          rwe[p] = (p == 1) && ($urandom_range(1) == 1);
          if (p == 0) begin bus.req0 = 1'b1; bus.addr0 = ra[0]; end
          else begin bus.req1 = 1'b1; bus.addr1 = ra[1]; bus.we1 = rwe[1]; bus.wdata1 = rw[1]; end
        end
      end
    end
    vectors++;
    if (acks != n) begin
      miscompares++; $display("FAIL rand_count: acks=%0d need %0d", acks, n);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata1 = '0;
    test_reset();
    test_single_fetch();
    test_stack_write();
    test_timeout();
    test_contention(7);
    test_reset_mid();
    test_contention(10);
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the processor's single-port memory between two requesters: instruction fetch (port 0, program counter side) and stack/data access (port 1, stack pointer side).
- Sequences each access as request -> memory enable -> wait for memory ready -> acknowledge. This replaces the combinational PC/SP address select at the top level.
- Sits between the processor core and the memory model. It adds a starvation guard for fetch and a timeout for an unresponsive memory.

Parameters:
- MAX_CONSEC, 4: maximum consecutive port-1 grants while port 0 is waiting.
- TIMEOUT, 16: cycles in ACCESS without mem_rdy before the access is aborted.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  fetch request; held until ack0.
- addr0  in  32  fetch address.
- req1  in  1  stack/data request; held until ack1.
- we1  in  1  port 1 write (1) / read (0).
- addr1  in  32  port 1 address.
- wdata1  in  32  port 1 write data.
- ack0  out  1  one-cycle completion pulse, port 0.
- ack1  out  1  one-cycle completion pulse, port 1.
- rdata  out  32  read data; valid while ack0/ack1 is high.
- err  out  1  pulses with ack when the access timed out.
- busy  out  1  high in ACCESS and RESP.
- gnt_id  out  1  currently granted port; holds its last value in IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; sampled when mem_rdy is high.
- mem_rdy  in  1  memory completion; sampled only in ACCESS.

Behaviour:
- Reset (rst high at an edge, from any state):
  - state goes to IDLE.
  - ack0, ack1, err, busy, mem_en, mem_we, gnt_id are 0.
  - mem_addr, mem_wdata, rdata are 0.
  - Timeout counter and consecutive-grant counter are 0.
  - An in-flight access is abandoned with no ack; a reset mid-ACCESS drops the access.
- FSM states IDLE, ACCESS, RESP; all outputs are registered.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If either request is high, select a winner and latch its address, data and we into mem_addr/mem_wdata/mem_we. Port 0 always forces mem_we=0.
  - Set mem_en=1, busy=1, gnt_id=winner, and go to ACCESS.
  - Latency: req sampled at edge N gives mem_en=1 in the cycle after edge N.
- Selection rules:
  - Only req1 high -> grant port 1. Only req0 high -> grant port 0.
  - Both high -> grant port 1, unless consec==MAX_CONSEC, in which case grant port 0.
  - consec increments (saturating at MAX_CONSEC) on each port-1 grant made while req0 is high.
  - consec clears on any port-0 grant; it is unchanged by a port-1 grant made with req0 low.
- ACCESS:
  - mem_en, mem_addr, mem_wdata and mem_we are held stable; tcnt increments each cycle.
  - mem_rdy=1 at an edge: latch rdata=mem_rdata (write: rdata=0), clear mem_en, pulse ack[gnt_id]=1, and go to RESP.
  - Otherwise, if tcnt==TIMEOUT-1: rdata=0, err=1, ack[gnt_id]=1, mem_en=0, go to RESP. So mem_en stays high for exactly TIMEOUT cycles.
- RESP:
  - Lasts one cycle; then ack, err and busy return to 0, tcnt=0, and the state goes to IDLE.
  - Requests are not sampled in RESP. The requester drops req in the cycle ack is seen.
  - Minimum spacing between mem_en pulses is 2 idle cycles (RESP + IDLE).
- Requester protocol:
  - req, addr, wdata and we must stay stable until ack.
  - A req deasserted during ACCESS does not cancel the access; the ack is still issued.
- ack0 and ack1 are never high together; err is high only together with an ack.

Test Plan:
- Reset: hold rst for 2 cycles with req0=req1=1 -> all outputs 0, no mem_en. After rst drops, the first grant is port 1.
- Single fetch: req0=1, addr0=0x0000_0010, memory returns 0xDEAD_BEEF with mem_rdy 2 cycles after mem_en -> mem_en high for 2 cycles with mem_addr=0x10, mem_we=0; then ack0=1 for one cycle with rdata=0xDEAD_BEEF, err=0.
- Stack write: req1=1, we1=1, addr1=0x0000_FFFC, wdata1=0x0000_0042 -> mem_we=1, mem_wdata=0x42; ack1 pulse; rdata=0.
- Contention/starvation: req0 and req1 continuously high, MAX_CONSEC=4, 1-cycle memory -> grant order 1,1,1,1,0,1,1,1,1,0...; never two acks in the same cycle.
- Timeout: req1 read, mem_rdy tied 0, TIMEOUT=16 -> mem_en high exactly 16 cycles; then ack1=1, err=1, rdata=0; arbiter returns to IDLE and serves the next request normally.
- Reset mid-access: assert rst during the 2nd ACCESS cycle -> mem_en=0 and IDLE after that edge, no ack0/ack1, consec=0.
